// File: rtl/conv1d_output_packer_if.sv
// conv1d_output_packer_if
//   Groups every non-clock/reset signal of conv1d_output_packer.
//   master : the side that produces results and reads packed words (bench / CPU glue)
//   slave  : the packer itself
//
// Handshake semantics (both directions):
//   in_valid/in_ready : in_data is transferred on a rising clk edge where
//                       in_valid && in_ready. in_valid may be raised
//                       regardless of in_ready; in_ready may depend on rd_en.
//   rd_valid/rd_en    : rd_data is the FIFO head whenever rd_valid=1; the head
//                       is consumed on a rising edge where rd_valid && rd_en.
//                       rd_en while rd_valid=0 is ignored.
//   flush             : one-cycle request; completion is reported by a
//                       one-cycle flush_done pulse.
//   clear             : synchronous, overrides everything else that cycle.
//   state_dbg         : 0 = PACK, 1 = FLUSH_WAIT (debug visibility of the FSM).
interface conv1d_output_packer_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          flush;
  logic          flush_done;
  logic          rd_en;
  logic          rd_valid;
  logic [31:0]   rd_data;
  logic [CW-1:0] count;
  logic          sat_flag;
  logic          clear;
  logic          state_dbg;

  modport master (
    output in_valid, in_data, flush, rd_en, clear,
    input  in_ready, flush_done, rd_valid, rd_data, count, sat_flag, state_dbg
  );

  modport slave (
    input  in_valid, in_data, flush, rd_en, clear,
    output in_ready, flush_done, rd_valid, rd_data, count, sat_flag, state_dbg
  );
endinterface

// File: rtl/conv1d_output_packer.sv
// conv1d_output_packer
//   Saturates each int32 quantized result to int8, packs four of them
//   little-endian (byte0 = oldest) into a 32-bit word and buffers the words
//   in a show-ahead FIFO. A flush pads and emits a partial word.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : conv1d_output_packer_if.slave (input handshake, flush, clear,
//            FIFO read port, count, sat_flag, state_dbg)
// Parameters:
//   FIFO_DEPTH : words buffered (power of two, >= 2)
//   PAD_BYTE   : fill value for unused lanes of a flushed partial word
module conv1d_output_packer #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst_n,
  conv1d_output_packer_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    PACK       = 1'b0,
    FLUSH_WAIT = 1'b1
  } state_t;

  state_t             state_q, state_n;
  logic [1:0]         byte_idx_q, byte_idx_n;
  logic [3:0][7:0]    lane_q, lane_n;

  logic [31:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q, rd_ptr_n;
  logic [CW-1:0]      count_q, count_n;
  logic               rd_valid_q;
  logic [31:0]        rd_data_q;
  logic               flush_done_q, flush_done_n;
  logic               sat_q;

  logic               fifo_full, pop, has_space;
  logic               in_ready_c, accept, push;
  logic [31:0]        push_word, pad_word;
  logic signed [31:0] din;
  logic [7:0]         sat_byte;
  logic               clamp_hit;

  // ---------------------------------------------------------------------------
  // FIFO status and saturation
  // ---------------------------------------------------------------------------
  assign fifo_full = (count_q == CW'(FIFO_DEPTH));
  // rd_valid_q always mirrors count_q != 0, so it is a safe pop qualifier.
  assign pop       = bus.rd_en && rd_valid_q;
  // A same-cycle pop frees the slot the push needs.
  assign has_space = !fifo_full || pop;
  assign rd_ptr_n  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

  assign din = bus.in_data;

  always_comb begin
    sat_byte  = din[7:0];
    clamp_hit = 1'b0;
    if (din > 32'sd127) begin
      sat_byte  = 8'h7f;
      clamp_hit = 1'b1;
    end else if (din < -32'sd128) begin
      sat_byte  = 8'h80;
      clamp_hit = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state, packing and push decisions
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n      = state_q;
    byte_idx_n   = byte_idx_q;
    lane_n       = lane_q;
    push         = 1'b0;
    push_word    = '0;
    pad_word     = '0;
    flush_done_n = 1'b0;
    in_ready_c   = 1'b0;
    accept       = 1'b0;

    // Only the byte that would complete a word needs FIFO space.
    in_ready_c = (state_q == PACK) && !((byte_idx_q == 2'd3) && !has_space);
    accept     = bus.in_valid && in_ready_c;

    if (accept) begin
      lane_n[byte_idx_q] = sat_byte;
      byte_idx_n         = byte_idx_q + 2'd1;
    end

    // Partial word after this cycle's byte (if any) has been merged in.
    for (int i = 0; i < 4; i++) begin
      pad_word[8*i +: 8] = (2'(i) < byte_idx_n) ? lane_n[i] : PAD_BYTE;
    end

    unique case (state_q)
      PACK: begin
        if (accept && (byte_idx_q == 2'd3)) begin
          push      = 1'b1;
          push_word = lane_n;
        end
        if (bus.flush) begin
          if (byte_idx_n == 2'd0) begin
            flush_done_n = 1'b1;
          end else if (has_space) begin
            push         = 1'b1;
            push_word    = pad_word;
            byte_idx_n   = 2'd0;
            flush_done_n = 1'b1;
          end else begin
            state_n = FLUSH_WAIT;
          end
        end
      end
      FLUSH_WAIT: begin
        if (has_space) begin
          push         = 1'b1;
          push_word    = pad_word;
          byte_idx_n   = 2'd0;
          flush_done_n = 1'b1;
          state_n      = PACK;
        end
      end
      default: state_n = PACK;
    endcase
  end

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_n = count_q + CW'(1);
      2'b01:   count_n = count_q - CW'(1);
      default: count_n = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PACK;
      byte_idx_q   <= 2'd0;
      lane_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      flush_done_q <= 1'b0;
      sat_q        <= 1'b0;
    end else if (bus.clear) begin
      state_q      <= PACK;
      byte_idx_q   <= 2'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      flush_done_q <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_n;
      byte_idx_q   <= byte_idx_n;
      lane_q       <= lane_n;
      rd_ptr_q     <= rd_ptr_n;
      count_q      <= count_n;
      rd_valid_q   <= (count_n != '0);
      flush_done_q <= flush_done_n;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (accept && clamp_hit) sat_q <= 1'b1;
      // Show-ahead head register. When the write lands on the slot that
      // becomes the head (FIFO empty after any pop), forward the new word.
      if (push || pop) begin
        if (push && (wr_ptr_q == rd_ptr_n)) rd_data_q <= push_word;
        else                                rd_data_q <= mem[rd_ptr_n];
      end
    end
  end

  // Storage array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push && !bus.clear) mem[wr_ptr_q] <= push_word;
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.flush_done = flush_done_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.count      = count_q;
  assign bus.sat_flag   = sat_q;
  assign bus.state_dbg  = (state_q == FLUSH_WAIT);
endmodule

// File: tb/tb_conv1d_output_packer.sv
module tb_conv1d_output_packer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_fail = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  conv1d_output_packer_if #(.FIFO_DEPTH(DEPTH)) bus();

  conv1d_output_packer #(.FIFO_DEPTH(DEPTH), .PAD_BYTE(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard / model ----------------
  logic [31:0] exp_q[$];   // packed words expected in the FIFO, head first
  logic [7:0]  pend_q[$];  // saturated bytes of the unfinished word
  bit          m_wait;     // a flush is waiting for FIFO space
  bit          m_sat;
  bit          m_fd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] padded_word();
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = (i < pend_q.size()) ? pend_q[i] : 8'h00;
    return w;
  endfunction

  task automatic model_step();
    bit  pop, full, ready, was_wait;
    int  v;
    logic [7:0] b;
    was_wait = m_wait;
    full     = (exp_q.size() == DEPTH);
    pop      = bus.rd_en && (exp_q.size() > 0);
    if (bus.clear) begin
      exp_q.delete(); pend_q.delete();
      m_wait = 0; m_sat = 0; m_fd = 0;
      return;
    end
    ready = !was_wait && !(pend_q.size() == 3 && full && !pop);
    m_fd = 0;
    if (pop) void'(exp_q.pop_front());
    if (bus.in_valid && ready) begin
      v = $signed(bus.in_data);
      if (v > 127)       begin b = 8'h7f; m_sat = 1; end
      else if (v < -128) begin b = 8'h80; m_sat = 1; end
      else               b = v[7:0];
      pend_q.push_back(b);
      if (pend_q.size() == 4) begin
        exp_q.push_back({pend_q[3], pend_q[2], pend_q[1], pend_q[0]});
        pend_q.delete();
      end
    end
    if (was_wait || bus.flush) begin
      if (pend_q.size() == 0) m_fd = 1;
      else if (!full || pop) begin
        exp_q.push_back(padded_word());
        pend_q.delete();
        m_fd = 1;
        m_wait = 0;
      end else m_wait = 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete(); pend_q.delete();
      m_wait = 0; m_sat = 0; m_fd = 0;
    end else begin
      model_step();
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit exp_ready;
    if (rst_n) begin
      exp_ready = !m_wait && !(pend_q.size() == 3 && exp_q.size() == DEPTH &&
                               !(bus.rd_en && exp_q.size() > 0));
      check("count",      32'(bus.count), 32'(exp_q.size()));
      check("rd_valid",   32'(bus.rd_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) check("rd_data", bus.rd_data, exp_q[0]);
      check("sat_flag",   32'(bus.sat_flag), 32'(m_sat));
      check("flush_done", 32'(bus.flush_done), 32'(m_fd));
      check("state",      32'(bus.state_dbg), 32'(m_wait));
      check("in_ready",   32'(bus.in_ready), 32'(exp_ready));
    end
  end

  // ---------------- driver tasks ----------------
  // Called at negedge+1; drives one cycle and returns at the next negedge+1.
  task automatic cycle(input bit v, input logic [31:0] d, input bit f,
                       input bit r, input bit c, output bit rdy);
    bus.in_valid = v; bus.in_data = d; bus.flush = f; bus.rd_en = r; bus.clear = c;
    #1 rdy = bus.in_ready;
    @(negedge clk); #1;
    bus.in_valid = 0; bus.in_data = '0; bus.flush = 0; bus.rd_en = 0; bus.clear = 0;
  endtask

  task automatic push_byte(input logic [31:0] d);
    bit rdy;
    for (int k = 0; k < 20; k++) begin
      cycle(1, d, 0, 0, 0, rdy);
      if (rdy) return;
    end
    n_vec++; n_fail++;
    $display("FAIL push_timeout: actual no accept in 20 cycles required accept of %h", d);
  endtask

  task automatic idle(input int n);
    bit rdy;
    for (int k = 0; k < n; k++) cycle(0, '0, 0, 0, 0, rdy);
  endtask

  task automatic pop_word();
    bit rdy;
    cycle(0, '0, 0, 1, 0, rdy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bit rdy;
    logic [31:0] w4[4];
    logic [31:0] w6[4];
    bus.in_valid = 0; bus.in_data = '0; bus.flush = 0; bus.rd_en = 0; bus.clear = 0;

    // reset values
    @(negedge clk); #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_data",  bus.rd_data, 32'h0);
    check("rst_count",    32'(bus.count), 32'd0);
    check("rst_fd",       32'(bus.flush_done), 32'd0);
    check("rst_sat",      32'(bus.sat_flag), 32'd0);
    @(negedge clk); #1 rst_n = 1;
    idle(1);

    // pack 1,-2,3,-4
    push_byte(32'd1); push_byte(-32'sd2); push_byte(32'd3); push_byte(-32'sd4);
    check("pack_word",  bus.rd_data, 32'hFC03FE01);
    check("pack_model", exp_q[0], 32'hFC03FE01);
    check("pack_count", 32'(bus.count), 32'd1);
    pop_word();
    check("pack_pop_count", 32'(bus.count), 32'd0);
    check("pack_pop_valid", 32'(bus.rd_valid), 32'd0);

    // saturation, then clear
    push_byte(32'd300); push_byte(-32'sd200); push_byte(32'd127); push_byte(-32'sd128);
    check("sat_word", bus.rd_data, 32'h807F807F);
    check("sat_flag_set", 32'(bus.sat_flag), 32'd1);
    cycle(0, '0, 0, 0, 1, rdy);
    check("clr_sat",   32'(bus.sat_flag), 32'd0);
    check("clr_count", 32'(bus.count), 32'd0);

    // flush partial word, then flush with nothing pending
    push_byte(32'd5); push_byte(32'd6);
    cycle(0, '0, 1, 0, 0, rdy);
    check("flush_done1", 32'(bus.flush_done), 32'd1);
    check("flush_word",  bus.rd_data, 32'h00000605);
    check("flush_count", 32'(bus.count), 32'd1);
    idle(1);
    check("flush_done_once", 32'(bus.flush_done), 32'd0);
    pop_word();
    cycle(0, '0, 1, 0, 0, rdy);
    check("flush0_done",  32'(bus.flush_done), 32'd1);
    check("flush0_count", 32'(bus.count), 32'd0);
    idle(1);

    // full backpressure
    for (int i = 0; i < 16; i++) push_byte(32'h10 + i);
    check("full_count", 32'(bus.count), 32'd4);
    push_byte(32'h20); push_byte(32'h21); push_byte(32'h22);
    cycle(1, 32'h23, 0, 0, 0, rdy);
    check("full_blocked", 32'(rdy), 32'd0);
    cycle(1, 32'h23, 0, 1, 0, rdy);
    check("full_accept_w_pop", 32'(rdy), 32'd1);
    check("full_count_same",   32'(bus.count), 32'd4);
    w4[0] = 32'h17161514; w4[1] = 32'h1B1A1918; w4[2] = 32'h1F1E1D1C; w4[3] = 32'h23222120;
    for (int i = 0; i < 4; i++) begin
      check("full_order", bus.rd_data, w4[i]);
      pop_word();
    end
    check("full_drained", 32'(bus.count), 32'd0);

    // flush while full
    for (int i = 0; i < 16; i++) push_byte(32'h30 + i);
    push_byte(32'h40); push_byte(32'h41);
    cycle(0, '0, 1, 0, 0, rdy);
    check("fw_state",    32'(bus.state_dbg), 32'd1);
    check("fw_in_ready", 32'(bus.in_ready), 32'd0);
    idle(1);
    check("fw_hold", 32'(bus.flush_done), 32'd0);
    pop_word();
    check("fw_done",     32'(bus.flush_done), 32'd1);
    check("fw_state_pk", 32'(bus.state_dbg), 32'd0);
    check("fw_count",    32'(bus.count), 32'd4);
    w6[0] = 32'h37363534; w6[1] = 32'h3B3A3938; w6[2] = 32'h3F3E3D3C; w6[3] = 32'h00004140;
    for (int i = 0; i < 4; i++) begin
      check("fw_order", bus.rd_data, w6[i]);
      pop_word();
    end

    // asynchronous reset mid-word
    push_byte(32'd300);
    for (int i = 1; i < 14; i++) push_byte(32'h50 + i);
    check("ar_pre_count", 32'(bus.count), 32'd3);
    #2 rst_n = 0;
    #1;
    check("ar_count",    32'(bus.count), 32'd0);
    check("ar_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("ar_rd_data",  bus.rd_data, 32'h0);
    check("ar_in_ready", 32'(bus.in_ready), 32'd1);
    check("ar_sat",      32'(bus.sat_flag), 32'd0);
    check("ar_fd",       32'(bus.flush_done), 32'd0);
    @(negedge clk); #1 rst_n = 1;
    idle(1);
    push_byte(32'h61); push_byte(32'h62); push_byte(32'h63); push_byte(32'h64);
    check("ar_post_count", 32'(bus.count), 32'd1);
    check("ar_post_word",  bus.rd_data, 32'h64636261);
    pop_word();
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/conv1d_output_packer.md
Name: conv1d_output_packer

Overview:
Downstream stage of the conv1d compute block. It accepts one quantized int32 result per completed output element, saturates each result to int8, and packs four results little-endian into 32-bit words. The words are buffered in a show-ahead FIFO, so the CPU can fetch four outputs per read instead of issuing one get-accumulator command per element. A flush pads and emits a partial word at the end of a row.

Parameters:
FIFO_DEPTH, 16, number of 32-bit words buffered; must be a power of two and at least 2.
PAD_BYTE, 8'h00, byte value used to fill unused lanes of a flushed partial word.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  a quantized result is presented on in_data
in_ready  out  1  packer accepts in_data this cycle
in_data  in  32  signed quantized result (quanted_acc)
flush  in  1  single-cycle request to emit the pending partial word
flush_done  out  1  one-cycle pulse: flush completed
rd_en  in  1  pop the FIFO head (ignored when rd_valid=0)
rd_valid  out  1  FIFO is non-empty
rd_data  out  32  FIFO head word (show-ahead); byte0 = oldest result
count  out  $clog2(FIFO_DEPTH)+1  number of words held in the FIFO
sat_flag  out  1  sticky: some input was outside [-128,127]
clear  in  1  synchronous: drops FIFO contents, partial word and sat_flag

Behaviour:
- Reset (rst_n=0, asynchronous): FIFO empty, byte_idx=0, state=PACK, in_ready=1, rd_valid=0, rd_data=0, count=0, flush_done=0, sat_flag=0. Reset mid-operation discards all pending data.
- Saturation: byte = clamp(in_data, -128, 127)[7:0]. Any clamp event sets sat_flag, which stays set until clear or reset.
- Acceptance: a byte is accepted when in_valid && in_ready. It is written into lane byte_idx of the pack register, and byte_idx increments modulo 4.
- Word push: accepting the byte at lane 3 pushes {lane3,lane2,lane1,lane0} into the FIFO in the same cycle. The word is visible on rd_data/rd_valid the next cycle when the FIFO was empty.
- in_ready = (state==PACK) && !(byte_idx==3 && fifo_full && !(rd_en && rd_valid)). Push with a simultaneous pop on a full FIFO is legal; count is unchanged.
- State PACK: if flush is sampled high:
  - byte_idx==0: flush_done pulses next cycle; no push.
  - else, if space exists (including a same-cycle pop): push the partial word with unused lanes = PAD_BYTE, byte_idx<=0, flush_done pulses next cycle.
  - else: go to FLUSH_WAIT.
- Flush with a simultaneous accepted input: the byte is included first. If that byte completes a word, the full word is pushed and the flush then has nothing pending (flush_done next cycle).
- State FLUSH_WAIT: in_ready=0. On the first cycle with space, push the padded word, byte_idx<=0, pulse flush_done the next cycle, return to PACK.
- Read: when rd_en && rd_valid, the head is popped at the clock edge and rd_data shows the next word. rd_en on an empty FIFO has no effect.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. Pointer wrap is modulo FIFO_DEPTH; full is count==FIFO_DEPTH.
- clear: takes priority over all same-cycle events. Empties the FIFO, sets byte_idx=0, state=PACK, clears sat_flag; no flush_done is generated.
- Storage: inferred block RAM with registered write and show-ahead read. All outputs are registered except in_ready.

Test Plan:
- Pack: push 1,-2,3,-4 -> one word 32'hFC03FE01, rd_valid=1 one cycle later, count=1; rd_en -> count=0, rd_valid=0.
- Saturation: push 300,-200,127,-128 -> word 32'h807F807F, sat_flag=1; clear -> sat_flag=0, count=0.
- Flush partial: push 5,6, then flush -> word 32'h00000605, flush_done pulses exactly once; flush with byte_idx=0 -> flush_done, count unchanged.
- Full backpressure: FIFO_DEPTH=4. Fill 4 words, then push 3 bytes -> in_ready=0 at lane 3. Pop once -> 4th byte accepted, count stays 4, words read out in order.
- Flush while full: 4 words plus 2 pending bytes, flush -> FLUSH_WAIT with in_ready=0. A pop pushes the padded word, flush_done next cycle, state returns to PACK.
- Async reset: assert rst_n=0 mid-word with 3 words queued -> all outputs read their reset values immediately without a clock edge; after release, a fresh 4-byte push yields count=1.
